// File: rtl/pi_control_mc.sv
// pi_control_mc
//   Time-multiplexed PI controller for NUM_CH motor channels. A single
//   multiplier/adder datapath updates one channel at a time. Each channel
//   takes four cycles: MULP, MULI, SUM, WRITE. Sample_tick starts a frame
//   by snapshotting all channel errors and enables.
//
//   Control law:    u_k = u_k1 + K_P*e_k + K_I*e_k1
//   Number format:  Q_WIDTH fractional bits throughout
//   Error input:    sign-magnitude
//   Internal state: two's complement
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-high reset
//   Sample_tick  one-cycle strobe that starts a control frame
//   Enable       per-channel enable, sampled at frame start
//   Error_k      packed sign-magnitude errors, N_WIDTH bits per channel
//   COMANDO_PWM  packed registered PWM commands, PWM_WIDTH bits per channel
//   Pwm_valid    one-cycle pulse after the last channel is written
//   Busy         high while a frame is in progress
//   Overrun      sticky: a tick arrived while Busy; cleared only by Reset
//
// Optional feature
//   PI_DEADBAND_EN: after saturation, integer parts >= DB_HIGH snap to full
//   scale and integer parts <= DB_LOW snap to 0. When it is not defined,
//   only plain saturation is applied.
//
// State table
//   state   | meaning
//   IDLE    | waiting for Sample_tick
//   MULP    | p = K_P * e_k for the current channel
//   MULI    | i = K_I * e_k1 for the current channel (same multiplier)
//   SUM     | u = u_k1 + p + i
//   WRITE   | saturate, update PWM and channel history, advance channel
//   DONE    | pulse Pwm_valid, drop Busy
module pi_control_mc #(
  parameter int                 NUM_CH    = 4,
  parameter int                 N_WIDTH   = 17,
  parameter int                 Q_WIDTH   = 8,
  parameter int                 PWM_WIDTH = 8,
  parameter logic [N_WIDTH-1:0] K_P       = 17'h000D9,
  parameter logic [N_WIDTH-1:0] K_I       = 17'h00014,
  parameter int                 DB_LOW    = 5,
  parameter int                 DB_HIGH   = 250
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Sample_tick,
  input  logic [NUM_CH-1:0]             Enable,
  input  logic [NUM_CH*N_WIDTH-1:0]     Error_k,
  output logic [NUM_CH*PWM_WIDTH-1:0]   COMANDO_PWM,
  output logic                          Pwm_valid,
  output logic                          Busy,
  output logic                          Overrun
);

  localparam int ACC_WIDTH  = N_WIDTH + 8;
  localparam int PROD_WIDTH = 2 * N_WIDTH;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [ACC_WIDTH-1:0] PWM_MAX   = ACC_WIDTH'((1 << PWM_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH-1:0] PWM_MAX_Q = PWM_MAX <<< Q_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_MULP, S_MULI, S_SUM, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]              ch_q, ch_d;
  logic [NUM_CH*N_WIDTH-1:0]    err_f_q, err_f_d;
  logic [NUM_CH-1:0]            en_f_q, en_f_d;
  logic signed [ACC_WIDTH-1:0]  p_q, p_d;
  logic signed [ACC_WIDTH-1:0]  i_q, i_d;
  logic signed [ACC_WIDTH-1:0]  u_q, u_d;
  logic [NUM_CH*PWM_WIDTH-1:0]  pwm_q, pwm_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic                         ovr_q, ovr_d;
  logic signed [N_WIDTH-1:0]    e_k1_q [NUM_CH];
  logic signed [N_WIDTH-1:0]    e_k1_d [NUM_CH];
  logic signed [ACC_WIDTH-1:0]  ctrl_k1_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0]  ctrl_k1_d [NUM_CH];

  // FSM control strobes
  logic start_frame, ld_p, ld_i, ld_u, wr_ch, frame_done, tick_ovr;
  logic last_ch;

  // Datapath nets
  logic [N_WIDTH-1:0]          err_cur;
  logic signed [N_WIDTH-1:0]   err_tc;
  logic signed [N_WIDTH-1:0]   ek1_cur;
  logic signed [N_WIDTH-1:0]   ek1_abs;
  logic                        mul_sign;
  logic [N_WIDTH-1:0]          mul_mag;
  logic [N_WIDTH-1:0]          mul_gain;
  logic [PROD_WIDTH-1:0]       prod;
  logic [ACC_WIDTH-1:0]        term_mag;
  logic signed [ACC_WIDTH-1:0] term;
  logic signed [ACC_WIDTH-1:0] u_int;
  logic [PWM_WIDTH-1:0]        sat_pwm;
  logic signed [ACC_WIDTH-1:0] sat_ctrl;

  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Sample_tick) state_d = S_MULP;
      S_MULP:  state_d = S_MULI;
      S_MULI:  state_d = S_SUM;
      S_SUM:   state_d = S_WRITE;
      S_WRITE: state_d = last_ch ? S_DONE : S_MULP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_frame = (state_q == S_IDLE) && Sample_tick;
    ld_p        = (state_q == S_MULP);
    ld_i        = (state_q == S_MULI);
    ld_u        = (state_q == S_SUM);
    wr_ch       = (state_q == S_WRITE);
    frame_done  = (state_q == S_DONE);
    // DONE still counts as busy, so a tick there is dropped and flagged.
    tick_ovr    = (state_q != S_IDLE) && Sample_tick;
  end

  // ---------------- Shared multiplier ----------------
  assign err_cur = err_f_q[ch_q*N_WIDTH +: N_WIDTH];
  assign ek1_cur = e_k1_q[ch_q];
  assign ek1_abs = ek1_cur[N_WIDTH-1] ? -ek1_cur : ek1_cur;

  // Sign-magnitude to two's complement; negative zero maps to 0.
  assign err_tc = err_cur[N_WIDTH-1] ? -{1'b0, err_cur[N_WIDTH-2:0]}
                                     :  {1'b0, err_cur[N_WIDTH-2:0]};

  always_comb begin
    if (state_q == S_MULI) begin
      mul_sign = ek1_cur[N_WIDTH-1];
      mul_mag  = ek1_abs;
      mul_gain = K_I;
    end else begin
      mul_sign = err_cur[N_WIDTH-1];
      mul_mag  = {1'b0, err_cur[N_WIDTH-2:0]};
      mul_gain = K_P;
    end
  end

  // Multiply magnitudes, then re-apply the sign, so the shift truncates
  // toward zero for negative terms as well.
  assign prod     = {{N_WIDTH{1'b0}}, mul_mag} * {{N_WIDTH{1'b0}}, mul_gain};
  assign term_mag = ACC_WIDTH'(prod >> Q_WIDTH);
  assign term     = mul_sign ? -term_mag : term_mag;

  // ---------------- Saturation / anti-windup ----------------
  assign u_int = u_q >>> Q_WIDTH;

  always_comb begin
    sat_pwm  = u_int[PWM_WIDTH-1:0];
    sat_ctrl = u_q;
    if (u_q[ACC_WIDTH-1]) begin
      sat_pwm  = '0;
      sat_ctrl = '0;
    end else if (u_int >= PWM_MAX) begin
      sat_pwm  = '1;
      sat_ctrl = PWM_MAX_Q;
    end
`ifdef PI_DEADBAND_EN
    if (u_int <= ACC_WIDTH'(DB_LOW)) begin
      sat_pwm  = '0;
      sat_ctrl = '0;
    end else if (u_int >= ACC_WIDTH'(DB_HIGH)) begin
      sat_pwm  = '1;
      sat_ctrl = PWM_MAX_Q;
    end
`endif
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    ch_d      = ch_q;
    err_f_d   = err_f_q;
    en_f_d    = en_f_q;
    p_d       = p_q;
    i_d       = i_q;
    u_d       = u_q;
    pwm_d     = pwm_q;
    e_k1_d    = e_k1_q;
    ctrl_k1_d = ctrl_k1_q;
    valid_d   = frame_done;
    busy_d    = busy_q;
    ovr_d     = ovr_q | tick_ovr;

    if (start_frame) begin
      err_f_d = Error_k;
      en_f_d  = Enable;
      ch_d    = '0;
      busy_d  = 1'b1;
    end
    if (frame_done) busy_d = 1'b0;

    if (ld_p) p_d = term;
    if (ld_i) i_d = term;
    if (ld_u) u_d = ctrl_k1_q[ch_q] + p_q + i_q;

    if (wr_ch) begin
      if (en_f_q[ch_q]) begin
        pwm_d[ch_q*PWM_WIDTH +: PWM_WIDTH] = sat_pwm;
        ctrl_k1_d[ch_q]                    = sat_ctrl;
        e_k1_d[ch_q]                       = err_tc;
      end else begin
        pwm_d[ch_q*PWM_WIDTH +: PWM_WIDTH] = '0;
        ctrl_k1_d[ch_q]                    = '0;
        e_k1_d[ch_q]                       = '0;
      end
      if (!last_ch) ch_d = ch_q + 1'b1;
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ch_q    <= '0;
      err_f_q <= '0;
      en_f_q  <= '0;
      p_q     <= '0;
      i_q     <= '0;
      u_q     <= '0;
      pwm_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        e_k1_q[c]    <= '0;
        ctrl_k1_q[c] <= '0;
      end
    end else begin
      ch_q      <= ch_d;
      err_f_q   <= err_f_d;
      en_f_q    <= en_f_d;
      p_q       <= p_d;
      i_q       <= i_d;
      u_q       <= u_d;
      pwm_q     <= pwm_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      e_k1_q    <= e_k1_d;
      ctrl_k1_q <= ctrl_k1_d;
    end
  end

  assign COMANDO_PWM = pwm_q;
  assign Pwm_valid   = valid_q;
  assign Busy        = busy_q;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_pi_control_mc.sv
// Directed bench for pi_control_mc: a table of frames with hand-computed
// PWM results (state carries over between rows), then a mid-frame reset
// and a tick landing in the DONE cycle.
module tb_pi_control_mc;
  localparam int NUM_CH    = 4;
  localparam int N_WIDTH   = 17;
  localparam int PWM_WIDTH = 8;
  localparam int LATENCY   = 4 * NUM_CH + 2;

`ifdef PI_DEADBAND_EN
  localparam logic [7:0] V1_P3 = 8'd0;
  localparam logic [7:0] V2_P3 = 8'd0;
  localparam logic [7:0] V3_P3 = 8'd84;
`else
  localparam logic [7:0] V1_P3 = 8'd3;
  localparam logic [7:0] V2_P3 = 8'd3;
  localparam logic [7:0] V3_P3 = 8'd88;
`endif

  logic                        Clk = 1'b0;
  logic                        Reset;
  logic                        Sample_tick;
  logic [NUM_CH-1:0]           Enable;
  logic [NUM_CH*N_WIDTH-1:0]   Error_k;
  logic [NUM_CH*PWM_WIDTH-1:0] COMANDO_PWM;
  logic                        Pwm_valid;
  logic                        Busy;
  logic                        Overrun;

  pi_control_mc dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Sample_tick (Sample_tick),
    .Enable      (Enable),
    .Error_k     (Error_k),
    .COMANDO_PWM (COMANDO_PWM),
    .Pwm_valid   (Pwm_valid),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NUM_CH-1:0]           en;
    logic [NUM_CH*N_WIDTH-1:0]   err;      // {e3, e2, e1, e0}
    logic [NUM_CH*PWM_WIDTH-1:0] exp_pwm;  // {p3, p2, p1, p0}
    int                          extra_at; // edge after which a second tick is driven, 0 = none
    logic                        exp_ovr;
  } vec_t;

  vec_t vecs [7];
  vec_t post_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   lat;
    logic busy1;
    lat   = 0;
    busy1 = 1'b0;
    @(posedge Clk); #1;
    Enable      = v.en;
    Error_k     = v.err;
    Sample_tick = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (n == 1) begin
        Sample_tick = 1'b0;
        busy1       = Busy;
      end
      if (n == v.extra_at)     Sample_tick = 1'b1;
      if (n == v.extra_at + 1) Sample_tick = 1'b0;
      if (Pwm_valid) begin
        lat = n;
        break;
      end
    end
    Sample_tick = 1'b0;
    check({tag, " latency"}, lat, LATENCY);
    check({tag, " busy_start"}, busy1, 1);
    check({tag, " busy_at_valid"}, Busy, 0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s pwm%0d", tag, c), COMANDO_PWM[c*PWM_WIDTH +: PWM_WIDTH],
            v.exp_pwm[c*PWM_WIDTH +: PWM_WIDTH]);
    check({tag, " overrun"}, Overrun, v.exp_ovr);
    @(posedge Clk); #1;
    check({tag, " valid_pulse"}, Pwm_valid, 0);
    check({tag, " no_restart"}, Busy, 0);
  endtask

  initial begin
    // Errors in sign-magnitude Q8: +10=0x00A00 -10=0x10A00 +200=0x0C800
    // -200=0x1C800 +4=0x00400 -0=0x10000 -1=0x10100 +100=0x06400
    vecs[0] = '{en: 4'hF, err: {17'h00400, 17'h0C800, 17'h10A00, 17'h00A00},
                exp_pwm: {V1_P3, 8'd169, 8'd0, 8'd8}, extra_at: 0, exp_ovr: 1'b0};
    vecs[1] = '{en: 4'hF, err: {17'h10000, 17'h0C800, 17'h00A00, 17'h00A00},
                exp_pwm: {V2_P3, 8'd255, 8'd7, 8'd17}, extra_at: 0, exp_ovr: 1'b0};
    vecs[2] = '{en: 4'hF, err: {17'h06400, 17'h00000, 17'h10100, 17'h00000},
                exp_pwm: {V3_P3, 8'd255, 8'd7, 8'd18}, extra_at: 0, exp_ovr: 1'b0};
    vecs[3] = '{en: 4'h7, err: {17'h06400, 17'h00000, 17'h00000, 17'h00000},
                exp_pwm: {8'd0, 8'd255, 8'd7, 8'd18}, extra_at: 0, exp_ovr: 1'b0};
    vecs[4] = '{en: 4'hF, err: {17'h00A00, 17'h1C800, 17'h00000, 17'h00A00},
                exp_pwm: {8'd8, 8'd85, 8'd7, 8'd26}, extra_at: 0, exp_ovr: 1'b0};
    vecs[5] = '{en: 4'hF, err: '0,
                exp_pwm: {8'd9, 8'd69, 8'd7, 8'd27}, extra_at: 5, exp_ovr: 1'b1};
    vecs[6] = '{en: 4'hF, err: '0,
                exp_pwm: {8'd9, 8'd69, 8'd7, 8'd27}, extra_at: 0, exp_ovr: 1'b1};
    post_rst = '{en: 4'h7, err: {17'h00400, 17'h0C800, 17'h10A00, 17'h00A00},
                 exp_pwm: {8'd0, 8'd169, 8'd0, 8'd8}, extra_at: 17, exp_ovr: 1'b1};

    Reset       = 1'b1;
    Sample_tick = 1'b0;
    Enable      = '0;
    Error_k     = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst pwm", COMANDO_PWM, 0);
    check("rst valid", Pwm_valid, 0);
    check("rst busy", Busy, 0);
    check("rst overrun", Overrun, 0);
    Reset = 1'b0;

    for (int k = 0; k < 7; k++)
      run_frame(vecs[k], $sformatf("v%0d", k));

    // Reset while channel 2 is in MULI (edge 10 after the tick is driven).
    @(posedge Clk); #1;
    Enable      = 4'hF;
    Error_k     = vecs[0].err;
    Sample_tick = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge Clk); #1;
      if (n == 1) Sample_tick = 1'b0;
    end
    check("midrst busy_before", Busy, 1);
    Reset = 1'b1;
    #1;
    check("midrst pwm", COMANDO_PWM, 0);
    check("midrst busy", Busy, 0);
    check("midrst valid", Pwm_valid, 0);
    check("midrst overrun", Overrun, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Clean frame from zero state; channel 3 disabled; tick lands in DONE.
    run_frame(post_rst, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
